// File: rtl/seq_stage_controller.sv
// Multi-cycle stage sequencer for the sequential Y86-64 core: owns PC and status,
// walks each instruction through the six datapath stages and parks in HALT on faults.
module seq_stage_controller #(
  parameter logic [63:0] START_PC    = 64'd32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic        instr_valid,
  input  logic        imem_error,
  input  logic        dmem_error,
  input  logic        mem_ready,
  input  logic [63:0] new_pc,
  output logic [63:0] PC,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic        pc_update_en,
  output logic [2:0]  stat,
  output logic        halted,
  output logic        busy,
  output logic [31:0] instr_count
);

  localparam int unsigned     WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         icode_q, icode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [63:0]        pc_q, pc_d;
  logic [2:0]         stat_q, stat_d;
  logic [31:0]        count_q, count_d;
  logic [5:0]         en_q, en_d;
  logic               busy_q, busy_d;
  logic               halted_q, halted_d;
  logic               is_mem_op;

  always_comb begin
    case (icode_q)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem_op = 1'b1;
      default:                            is_mem_op = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    icode_d = icode_q;
    wait_d  = '0;
    pc_d    = pc_q;
    stat_d  = stat_q;
    count_d = count_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_FETCH;
      S_FETCH: begin
        icode_d = icode;
        if (imem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (!instr_valid) begin
          stat_d  = STAT_INS;
          state_d = S_HALT;
        end else if (icode == 4'h0) begin
          stat_d  = STAT_HLT;
          state_d = S_HALT;
        end else begin
          state_d = S_DECODE;
        end
      end
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_MEMORY;
      // wait_q counts MEMORY cycles already spent, so the timeout fires on cycle MEM_TIMEOUT
      S_MEMORY: begin
        if (!is_mem_op) begin
          state_d = S_WRITEBACK;
        end else if (dmem_error) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else if (mem_ready) begin
          state_d = S_WRITEBACK;
        end else if (wait_q == WAIT_LAST) begin
          stat_d  = STAT_ADR;
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD: begin
        pc_d = new_pc;
        if (count_q != 32'hFFFF_FFFF) count_d = count_q + 32'd1;
        state_d = S_FETCH;
      end
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase

    en_d = '0;
    case (state_d)
      S_FETCH:     en_d[0] = 1'b1;
      S_DECODE:    en_d[1] = 1'b1;
      S_EXECUTE:   en_d[2] = 1'b1;
      S_MEMORY:    en_d[3] = 1'b1;
      S_WRITEBACK: en_d[4] = 1'b1;
      S_PCUPD:     en_d[5] = 1'b1;
      default:     en_d    = '0;
    endcase
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      icode_q  <= 4'h0;
      wait_q   <= '0;
      pc_q     <= START_PC;
      stat_q   <= STAT_AOK;
      count_q  <= 32'd0;
      en_q     <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      icode_q  <= icode_d;
      wait_q   <= wait_d;
      pc_q     <= pc_d;
      stat_q   <= stat_d;
      count_q  <= count_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  assign PC           = pc_q;
  assign fetch_en     = en_q[0];
  assign decode_en    = en_q[1];
  assign execute_en   = en_q[2];
  assign memory_en    = en_q[3];
  assign writeback_en = en_q[4];
  assign pc_update_en = en_q[5];
  assign stat         = stat_q;
  assign halted       = halted_q;
  assign busy         = busy_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Self-checking bench: an instruction-level model plans the expected stage trace
// for each instruction and the bench compares the DUT cycle by cycle against it.
module tb_seq_stage_controller;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset, start, instr_valid, imem_error, dmem_error, mem_ready;
  logic [3:0]  icode;
  logic [63:0] new_pc, PC;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, pc_update_en;
  logic [2:0]  stat;
  logic        halted, busy;
  logic [31:0] instr_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic [31:0] m_count;
  logic [2:0]  m_stat;
  bit          m_halted;

  typedef struct {
    int stg;
    bit rdy;
    bit derr;
  } cyc_t;

  wire [5:0] en_obs = {pc_update_en, writeback_en, memory_en, execute_en, decode_en, fetch_en};

  seq_stage_controller #(.START_PC(64'd32), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .dmem_error(dmem_error), .mem_ready(mem_ready), .new_pc(new_pc),
    .PC(PC), .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .pc_update_en(pc_update_en),
    .stat(stat), .halted(halted), .busy(busy), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
    m_pc = 64'd32;
    m_count = 32'd0;
    m_stat = 3'd1;
    m_halted = 1'b0;
  endtask

  task automatic begin_run();
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (en_obs !== 6'b000001 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL start_to_fetch: en=%b busy=%b required en=000001 busy=1", en_obs, busy);
    end
  endtask

  // Plans the stage trace of one instruction from the stage rules, drives it and checks it.
  task automatic run_instr(input logic [3:0] ic, input bit iv, input bit ie,
                           input int delay, input int dat, input logic [63:0] npc);
    cyc_t plan[$];
    logic [2:0] fault;
    bit is_mem;
    is_mem = ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
    fault = ie ? 3'd3 : (!iv ? 3'd4 : ((ic == 4'h0) ? 3'd2 : 3'd0));
    plan.push_back(cyc_t'{0, 1'b0, 1'b0});
    if (fault == 3'd0) begin
      plan.push_back(cyc_t'{1, 1'b0, 1'b0});
      plan.push_back(cyc_t'{2, 1'b0, 1'b0});
      if (!is_mem) begin
        plan.push_back(cyc_t'{3, 1'($urandom), 1'($urandom)});
      end else begin
        for (int k = 0; k < TO; k++) begin
          if (k == dat) begin
            plan.push_back(cyc_t'{3, 1'b1, 1'b1});
            fault = 3'd3;
            break;
          end
          if (k >= delay) begin
            plan.push_back(cyc_t'{3, 1'b1, 1'b0});
            break;
          end
          plan.push_back(cyc_t'{3, 1'b0, 1'b0});
          if (k == TO - 1) fault = 3'd3;
        end
      end
      if (fault == 3'd0) begin
        plan.push_back(cyc_t'{4, 1'b0, 1'b0});
        plan.push_back(cyc_t'{5, 1'b0, 1'b0});
      end
    end

    foreach (plan[i]) begin
      checks++;
      if (en_obs !== 6'(1 << plan[i].stg) || busy !== 1'b1 || halted !== 1'b0 || PC !== m_pc) begin
        errors++;
        $display("[TB] FAIL stage_walk icode=%h cycle %0d: en=%b busy=%b halted=%b pc=%0h required en=%b busy=1 halted=0 pc=%0h",
                 ic, i, en_obs, busy, halted, PC, 6'(1 << plan[i].stg), m_pc);
      end
      start       = 1'($urandom);
      icode       = (plan[i].stg == 0) ? ic : 4'($urandom);
      instr_valid = (plan[i].stg == 0) ? iv : 1'b1;
      imem_error  = (plan[i].stg == 0) ? ie : 1'b0;
      mem_ready   = (plan[i].stg == 3) ? plan[i].rdy  : 1'($urandom);
      dmem_error  = (plan[i].stg == 3) ? plan[i].derr : 1'($urandom);
      new_pc      = (plan[i].stg == 5) ? npc : {$urandom, $urandom};
      step();
    end
    start = 1'b0;

    if (fault != 3'd0) begin
      m_stat = fault;
      m_halted = 1'b1;
    end else begin
      m_pc = npc;
      if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    end
    checks++;
    if (en_obs !== (m_halted ? 6'b000000 : 6'b000001) || stat !== m_stat || PC !== m_pc ||
        instr_count !== m_count || halted !== m_halted || busy !== 1'(!m_halted)) begin
      errors++;
      $display("[TB] FAIL instr_result icode=%h: en=%b stat=%0d pc=%0h count=%0d halted=%b busy=%b required en=%b stat=%0d pc=%0h count=%0d halted=%b",
               ic, en_obs, stat, PC, instr_count, halted, busy,
               (m_halted ? 6'b000000 : 6'b000001), m_stat, m_pc, m_count, m_halted);
    end
  endtask

  task automatic test_halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      start  = 1'b1;
      icode  = 4'($urandom);
      mem_ready = 1'($urandom);
      new_pc = {$urandom, $urandom};
      step();
      checks++;
      if (en_obs !== 6'b0 || halted !== 1'b1 || busy !== 1'b0 || stat !== m_stat ||
          PC !== m_pc || instr_count !== m_count) begin
        errors++;
        $display("[TB] FAIL halt_hold: en=%b halted=%b busy=%b stat=%0d pc=%0h count=%0d required en=0 halted=1 busy=0 stat=%0d pc=%0h count=%0d",
                 en_obs, halted, busy, stat, PC, instr_count, m_stat, m_pc, m_count);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (en_obs !== 6'b0 || PC !== 64'd32 || stat !== 3'd1 || halted !== 1'b0 ||
          busy !== 1'b0 || instr_count !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_idle: en=%b pc=%0h stat=%0d halted=%b busy=%b count=%0d required en=0 pc=20 stat=1 halted=0 busy=0 count=0",
                 en_obs, PC, stat, halted, busy, instr_count);
      end
      step();
    end
  endtask

  task automatic test_basic();
    do_reset();
    begin_run();
    run_instr(4'h6, 1'b1, 1'b0, 0, -1, 64'd34);
  endtask

  task automatic test_mem_wait();
    run_instr(4'h5, 1'b1, 1'b0, 3, -1, 64'h1234);
  endtask

  task automatic test_halt();
    do_reset();
    begin_run();
    run_instr(4'h6, 1'b1, 1'b0, 0, -1, 64'd40);
    run_instr(4'h0, 1'b1, 1'b0, 0, -1, 64'd99);
    test_halt_hold(4);
  endtask

  task automatic test_priority();
    do_reset();
    begin_run();
    run_instr(4'h3, 1'b0, 1'b1, 0, -1, 64'd50);
    do_reset();
    begin_run();
    run_instr(4'h0, 1'b0, 1'b0, 0, -1, 64'd50);
  endtask

  task automatic test_timeout();
    do_reset();
    begin_run();
    run_instr(4'hA, 1'b1, 1'b0, 1000, -1, 64'd77);
    test_halt_hold(2);
    do_reset();
    begin_run();
    run_instr(4'hB, 1'b1, 1'b0, 0, 0, 64'd78);
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_run();
    run_instr(4'h6, 1'b1, 1'b0, 0, -1, 64'd100);
    icode = 4'h6;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    step();
    step();
    checks++;
    if (execute_en !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reach_execute: execute_en=%b required 1", execute_en);
    end
    do_reset();
    checks++;
    if (en_obs !== 6'b0 || PC !== 64'd32 || stat !== 3'd1 || instr_count !== 32'd0 ||
        busy !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_execute: en=%b pc=%0h stat=%0d count=%0d busy=%b halted=%b required en=0 pc=20 stat=1 count=0 busy=0 halted=0",
               en_obs, PC, stat, instr_count, busy, halted);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    begin_run();
    for (int n = 0; n < 120; n++) begin
      if (m_halted) begin
        test_halt_hold(2);
        do_reset();
        begin_run();
      end
      r = $urandom_range(0, 19);
      run_instr((r == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                $urandom_range(0, 15) != 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 9),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1,
                {$urandom, $urandom});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    icode = 4'h0;
    instr_valid = 1'b1;
    imem_error = 1'b0;
    dmem_error = 1'b0;
    mem_ready = 1'b0;
    new_pc = 64'd0;
    test_reset();
    test_basic();
    test_mem_wait();
    test_halt();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
